// File: rtl/mem_burst_master_pkg.sv
// ============================================================================
// mem_pkg : shared types and default widths for the burst master slice
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_LEN_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_burst_master_if.sv
// ============================================================================
// mem_burst_master_if : client request/beat channels plus memory port
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_burst_master_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  logic              done;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    output req_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output done,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    input  req_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  done,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_burst_master_addr_counter.sv
// ============================================================================
// mem_addr_counter : loadable wrapping address plus beat down-counter
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_addr_counter #(
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 3
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load_i,
  input  wire logic [ADDR_W-1:0] addr_i,
  input  wire logic [LEN_W-1:0]  len_i,
  input  wire logic              step_i,
  output logic      [ADDR_W-1:0] addr_o,
  output logic                   last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  // Address wraps naturally at 2**ADDR_W; count reaching zero marks the final beat.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = addr_i;
      cnt_d  = len_i;
    end else if (step_i) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_burst_master.sv
// ============================================================================
// mem_burst_master : burst read/write initiator for a small async-read memory
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_burst_master
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input wire logic           clk,
  input wire logic           rst_n,
  mem_burst_master_if.master bus
);

  state_e            state_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              accept;
  logic              wr_beat;
  logic              rd_load;
  logic [ADDR_W-1:0] cur_addr;
  logic              cnt_last;

  assign accept  = (state_q == ST_IDLE)  && bus.req_valid;
  assign wr_beat = (state_q == ST_WRITE) && bus.wr_valid;
  // The output register refills whenever it is empty or its beat is being taken.
  assign rd_load = (state_q == ST_READ)  && (!rd_valid_q || bus.rd_ready);

  mem_addr_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .addr_i (bus.req_addr),
    .len_i  (bus.req_len),
    .step_i (wr_beat || rd_load),
    .addr_o (cur_addr),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            state_q <= bus.req_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (bus.wr_valid && cnt_last) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (rd_load) begin
            rd_data_q  <= bus.mem_rdata;
            rd_valid_q <= 1'b1;
            rd_last_q  <= cnt_last;
            if (cnt_last) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.wr_ready  = (state_q == ST_WRITE);
  assign bus.mem_we    = wr_beat;
  assign bus.mem_addr  = cur_addr;
  assign bus.mem_wdata = bus.wr_data;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_master.sv
// ============================================================================
// tb_mem_burst_master : directed bursts against a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_burst_master;

  localparam int P_IDLE = 0;
  localparam int P_WR   = 1;
  localparam int P_RD   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;

  logic [31:0] mem     [8] = '{32'h1000, 32'h1001, 32'h1002, 32'h1003,
                               32'h1004, 32'h1005, 32'h1006, 32'h1007};
  logic [31:0] ref_mem [8] = '{32'h1000, 32'h1001, 32'h1002, 32'h1003,
                               32'h1004, 32'h1005, 32'h1006, 32'h1007};
  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  int       m_phase = P_IDLE;
  logic [2:0] m_start = '0;
  logic [2:0] m_cur   = '0;
  int       m_total = 0;
  int       m_cnt   = 0;
  int       m_k     = 0;
  logic     m_rv    = 1'b0;
  logic     m_done  = 1'b0;

  always #5 clk = ~clk;

  mem_burst_master_if bus ();

  mem_burst_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: one beat per cycle while the channel moves, read beats
  // are shown in order from the start address and advance only on acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE;
      m_cur   <= '0;
      m_rv    <= 1'b0;
      m_done  <= 1'b0;
      m_k     <= 0;
    end else begin
      m_done <= 1'b0;
      case (m_phase)
        P_IDLE: if (bus.req_valid) begin
          m_phase <= bus.req_write ? P_WR : P_RD;
          m_start <= bus.req_addr;
          m_cur   <= bus.req_addr;
          m_total <= int'(bus.req_len) + 1;
          m_cnt   <= 0;
        end
        P_WR: if (bus.wr_valid) begin
          ref_mem[m_cur] <= bus.wr_data;
          m_cur <= m_cur + 3'd1;
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == m_total) begin
            m_phase <= P_IDLE;
            m_done  <= 1'b1;
          end
        end
        P_RD: if (!m_rv) begin
          m_rv  <= 1'b1;
          m_k   <= 0;
          m_cur <= m_start + 3'd1;
        end else if (bus.rd_ready) begin
          if (m_k == m_total - 1) begin
            m_rv    <= 1'b0;
            m_phase <= P_IDLE;
            m_done  <= 1'b1;
          end else begin
            m_k   <= m_k + 1;
            m_cur <= m_start + 3'(m_k + 2);
          end
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("req_ready", 32'(bus.req_ready), 32'(m_phase == P_IDLE));
    chk("wr_ready",  32'(bus.wr_ready),  32'(m_phase == P_WR));
    chk("mem_we",    32'(bus.mem_we),    32'(m_phase == P_WR && bus.wr_valid));
    chk("mem_addr",  32'(bus.mem_addr),  32'(m_cur));
    chk("mem_wdata", bus.mem_wdata,      bus.wr_data);
    chk("rd_valid",  32'(bus.rd_valid),  32'(m_rv));
    chk("done",      32'(bus.done),      32'(m_done));
    if (m_rv) begin
      chk("rd_data", bus.rd_data,        ref_mem[m_start + 3'(m_k)]);
      chk("rd_last", 32'(bus.rd_last),   32'(m_k == m_total - 1));
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.rd_valid && bus.rd_ready) got.push_back(bus.rd_data);
    if (bus.done) n_done++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic wr, input logic [2:0] a, input logic [2:0] l);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_len   = l;
    cyc();
    bus.req_valid = 1'b0;
  endtask

  task automatic write_beats(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = base + 32'(i);
      cyc();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input logic toggle);
    int k = 0;
    while (bus.req_ready !== 1'b1 && k < 100) begin
      if (toggle) bus.rd_ready = ~bus.rd_ready;
      cyc();
      k++;
    end
    chk({nm, "_timeout"}, 32'(k < 100), 32'd1);
  endtask

  task automatic check_got(input string nm);
    chk({nm, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s_beat%0d", nm, i), got[i], exp_q[i]);
    end
  endtask

  initial begin
    int d0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    repeat (2) cyc();
    chk("rst_rd_data",   bus.rd_data,         32'h0);
    chk("rst_rd_valid",  32'(bus.rd_valid),   32'd0);
    chk("rst_req_ready", 32'(bus.req_ready),  32'd1);
    chk("rst_mem_addr",  32'(bus.mem_addr),   32'd0);
    rst_n = 1'b1;
    cyc();

    // Wrapping write burst
    d0 = n_done;
    send_req(1'b1, 3'd6, 3'd3);
    write_beats(4, 32'hA0);
    wait_idle("t1", 1'b0);
    cyc();
    chk("t1_mem6", mem[6], 32'hA0);
    chk("t1_mem7", mem[7], 32'hA1);
    chk("t1_mem0", mem[0], 32'hA2);
    chk("t1_mem1", mem[1], 32'hA3);
    chk("t1_done_pulses", 32'(n_done - d0), 32'd1);

    // Wrapping read burst, always ready
    got.delete();
    bus.rd_ready = 1'b1;
    send_req(1'b0, 3'd6, 3'd3);
    wait_idle("t2", 1'b0);
    cyc();
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    check_got("t2");

    // Full-length read with alternating back-pressure
    got.delete();
    send_req(1'b0, 3'd0, 3'd7);
    wait_idle("t3", 1'b1);
    bus.rd_ready = 1'b1;
    cyc();
    exp_q = '{32'hA2, 32'hA3, 32'h1002, 32'h1003, 32'h1004, 32'h1005, 32'hA0, 32'hA1};
    check_got("t3");

    // Single-beat write then read
    send_req(1'b1, 3'd3, 3'd0);
    write_beats(1, 32'hC3);
    wait_idle("t4w", 1'b0);
    cyc();
    got.delete();
    send_req(1'b0, 3'd3, 3'd0);
    wait_idle("t4r", 1'b0);
    cyc();
    exp_q = '{32'hC3};
    check_got("t4");

    // Request held across a busy write; re-accepted on the done cycle
    d0 = n_done;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 3'd2;
    bus.req_len   = 3'd1;
    cyc();
    chk("t5_busy_ready", 32'(bus.req_ready), 32'd0);
    write_beats(2, 32'hD0);
    chk("t5_done_cycle", 32'(bus.done), 32'd1);
    chk("t5_ready_on_done", 32'(bus.req_ready), 32'd1);
    cyc();
    bus.req_valid = 1'b0;
    chk("t5_second_accepted", 32'(bus.wr_ready), 32'd1);
    write_beats(2, 32'hD8);
    wait_idle("t5", 1'b0);
    cyc();
    chk("t5_mem2", mem[2], 32'hD8);
    chk("t5_mem3", mem[3], 32'hD9);
    chk("t5_done_pulses", 32'(n_done - d0), 32'd2);

    // Reset after two of four beats
    send_req(1'b1, 3'd4, 3'd3);
    write_beats(2, 32'hE0);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("t6_we_in_reset",    32'(bus.mem_we),    32'd0);
    chk("t6_ready_in_reset", 32'(bus.req_ready), 32'd1);
    chk("t6_addr_in_reset",  32'(bus.mem_addr),  32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("t6_mem4", mem[4], 32'hE0);
    chk("t6_mem5", mem[5], 32'hE1);
    chk("t6_mem6", mem[6], 32'hA0);
    chk("t6_mem7", mem[7], 32'hA1);
    chk("t6_no_done", 32'(n_done - d0), 32'd0);

    for (int i = 0; i < 8; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
